// File: rtl/add_negate_unit.sv
// add_negate_unit: registered add / subtract / negate / pass datapath for the
// CPU ALU. Subtract is Ra + NEG(Rb) + cin, where NEG(x) = ~x + 1 comes from a
// second instance of the same carry-lookahead adder core.
// Optional feature macro: ADD_NEGATE_OVF_EN adds a registered signed-overflow
// output ovf with the same timing as sum/cout.

module add_negate_cla #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);
   localparam int NBLK = WIDTH / 4;

   if (WIDTH % 4 != 0) begin : g_width_chk
      $error("add_negate_cla: WIDTH must be a multiple of 4");
   end

   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [NBLK:0]    c_blk;

   assign g        = a & b;
   assign p        = a ^ b;
   assign c_blk[0] = c_in;

   // Each 4-bit block resolves its internal carries in parallel from g/p;
   // only the block carry ripples to the next block.
   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      logic [3:0] gg;
      logic [3:0] pp;
      logic [4:0] c;

      assign gg   = g[4*k +: 4];
      assign pp   = p[4*k +: 4];
      assign c[0] = c_blk[k];
      assign c[1] = gg[0] | (pp[0] & c[0]);
      assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
      assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & c[0]);
      assign c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0])
                  | (pp[3] & pp[2] & pp[1] & pp[0] & c[0]);

      assign s[4*k +: 4] = pp ^ c[3:0];
      assign c_blk[k+1]  = c[4];
   end

   assign c_out = c_blk[NBLK];
endmodule

module add_negate_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADD_NEGATE_OVF_EN
  ,output logic             ovf
`endif
);
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_NEG  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;
   localparam int         MSB     = WIDTH - 1;

   logic [WIDTH-1:0] neg_rb;
   logic             unused_neg_cout;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_s;
   logic             add_c;
   logic [WIDTH-1:0] sum_p0;
   logic             cout_p0;
   logic             vld_p1;
   logic [WIDTH-1:0] sum_p1;
   logic             cout_p1;

   // Negator: ~Rb + 1; its carry out only fires for Rb == 0 and is not needed.
   add_negate_cla #(.WIDTH(WIDTH)) u_neg (
      .a     (~Rb),
      .b     ({WIDTH{1'b0}}),
      .c_in  (1'b1),
      .s     (neg_rb),
      .c_out (unused_neg_cout)
   );

   assign add_b = (op == OP_SUB) ? neg_rb : Rb;

   add_negate_cla #(.WIDTH(WIDTH)) u_add (
      .a     (Ra),
      .b     (add_b),
      .c_in  (cin),
      .s     (add_s),
      .c_out (add_c)
   );

   // Result select: only ADD/SUB report the adder carry.
   always_comb begin
      sum_p0  = Ra;
      cout_p0 = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            sum_p0  = add_s;
            cout_p0 = add_c;
         end
         OP_NEG:  sum_p0 = neg_rb;
         OP_PASS: sum_p0 = Ra;
         default: sum_p0 = Ra;
      endcase
   end

`ifdef ADD_NEGATE_OVF_EN
   logic ovf_p0;
   logic ovf_p1;

   // Signed overflow: same-sign operands giving a result of the other sign;
   // NEG overflows only for the most negative value (its negation is itself).
   always_comb begin
      ovf_p0 = 1'b0;
      case (op)
         OP_ADD, OP_SUB: ovf_p0 = (Ra[MSB] == add_b[MSB]) && (add_s[MSB] != Ra[MSB]);
         OP_NEG:         ovf_p0 = Rb[MSB] & neg_rb[MSB];
         default:        ovf_p0 = 1'b0;
      endcase
   end

   // Overflow flag register, same timing and reset as sum/cout.
   always_ff @(posedge clk) begin
      if (clr) begin
         ovf_p1 <= 1'b0;
      end else if (in_valid) begin
         ovf_p1 <= ovf_p0;
      end
   end

   assign ovf = ovf_p1;
`endif

   // ---- stage p0 -> p1: result register; holds when no new operation ----
   always_ff @(posedge clk) begin
      if (clr) begin
         vld_p1  <= 1'b0;
         sum_p1  <= {WIDTH{1'b0}};
         cout_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            sum_p1  <= sum_p0;
            cout_p1 <= cout_p0;
         end
      end
   end

   assign out_valid = vld_p1;
   assign sum       = sum_p1;
   assign cout      = cout_p1;
endmodule

// File: tb/tb_add_negate_unit.sv
// tb_add_negate_unit: directed and randomized checks of add_negate_unit
// against a plain-arithmetic reference model. Honours ADD_NEGATE_OVF_EN.

module tb_add_negate_unit;
   logic        clk;
   logic        clr;
   logic        in_valid;
   logic [1:0]  op;
   logic [31:0] Ra;
   logic [31:0] Rb;
   logic        cin;
   logic        out_valid;
   logic [31:0] sum;
   logic        cout;
`ifdef ADD_NEGATE_OVF_EN
   logic        ovf;
`endif

   int checks;
   int failures;

   logic [31:0] exp_sum;
   logic        exp_cout;
   logic        exp_ovf;

   add_negate_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .op        (op),
      .Ra        (Ra),
      .Rb        (Rb),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout)
`ifdef ADD_NEGATE_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 33-bit unsigned sum for the carry, 64-bit signed sum
   // for overflow (true result outside the 32-bit signed range).
   function automatic void model(input logic [1:0] mop, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci,
                                 output logic [31:0] s, output logic co,
                                 output logic ov);
      logic [32:0] t;
      logic [31:0] n;
      longint      r;
      n  = 32'd0 - b;
      s  = a;
      co = 1'b0;
      ov = 1'b0;
      r  = 0;
      case (mop)
         2'd0: begin
            t  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            s  = t[31:0];
            co = t[32];
            r  = longint'($signed(a)) + longint'($signed(b)) + longint'({31'd0, ci});
            ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         2'd1: begin
            t  = {1'b0, a} + {1'b0, n} + {32'd0, ci};
            s  = t[31:0];
            co = t[32];
            r  = longint'($signed(a)) + longint'($signed(n)) + longint'({31'd0, ci});
            ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         2'd2: begin
            s  = n;
            ov = (b == 32'h8000_0000);
         end
         default: s = a;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
      in_valid = 1'b1;
      op       = o;
      Ra       = a;
      Rb       = b;
      cin      = c;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      clr = 1'b1;
      drive(2'd0, 32'd5, 32'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL reset[%0d]: got vld=%b sum=%h cout=%b, need vld=0 sum=0 cout=0",
                     i, out_valid, sum, cout);
         end
`ifdef ADD_NEGATE_OVF_EN
         checks++;
         if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf[%0d]: got %b need 0", i, ovf);
         end
`endif
      end
      clr = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || sum !== 32'd5 || cout !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got vld=%b sum=%h cout=%b, need vld=1 sum=5 cout=0",
                  out_valid, sum, cout);
      end
   endtask

   task automatic test_add();
      logic [31:0] a[3] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] b[3] = '{32'd1, 32'd1, 32'd0};
      logic        c[3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] s[3] = '{32'd2, 32'd0, 32'd0};
      logic        co[3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(2'd0, a[i], b[i], c[i]);
         step();
         checks++;
         if (out_valid !== 1'b1 || sum !== s[i] || cout !== co[i]) begin
            failures++;
            $display("FAIL add[%0d]: got vld=%b sum=%h cout=%b, need vld=1 sum=%h cout=%b",
                     i, out_valid, sum, cout, s[i], co[i]);
         end
      end
   endtask

   task automatic test_sub();
      logic [31:0] a[4] = '{32'd1, 32'd235, 32'd20, 32'd7};
      logic [31:0] b[4] = '{32'd1, 32'd35, 32'd25, 32'd0};
      logic [31:0] s[4] = '{32'd0, 32'd200, 32'hFFFF_FFFB, 32'd7};
      logic        co[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(2'd1, a[i], b[i], 1'b0);
         step();
         checks++;
         if (out_valid !== 1'b1 || sum !== s[i] || cout !== co[i]) begin
            failures++;
            $display("FAIL sub[%0d]: got vld=%b sum=%h cout=%b, need vld=1 sum=%h cout=%b",
                     i, out_valid, sum, cout, s[i], co[i]);
         end
      end
   endtask

   task automatic test_neg();
      logic [31:0] b[3] = '{32'd1, 32'd0, 32'h8000_0000};
      logic [31:0] s[3] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
      logic        ov[3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(2'd2, 32'h1234_5678, b[i], 1'b1);
         step();
         checks++;
         if (out_valid !== 1'b1 || sum !== s[i] || cout !== 1'b0) begin
            failures++;
            $display("FAIL neg[%0d]: got vld=%b sum=%h cout=%b, need vld=1 sum=%h cout=0",
                     i, out_valid, sum, cout, s[i]);
         end
`ifdef ADD_NEGATE_OVF_EN
         checks++;
         if (ovf !== ov[i]) begin
            failures++;
            $display("FAIL neg_ovf[%0d]: got %b need %b", i, ovf, ov[i]);
         end
`else
         if (ov[i] === 1'bx) $display("note: unreachable");
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      for (int i = 0; i < 10; i++) begin
         o = 2'($urandom_range(0, 3));
         a = rand_operand();
         b = rand_operand();
         c = 1'($urandom_range(0, 1));
         model(o, a, b, c, exp_sum, exp_cout, exp_ovf);
         drive(o, a, b, c);
         step();
         checks++;
         if (out_valid !== 1'b1 || sum !== exp_sum || cout !== exp_cout) begin
            failures++;
            $display("FAIL b2b[%0d] op=%0d a=%h b=%h cin=%b: got vld=%b sum=%h cout=%b, need vld=1 sum=%h cout=%b",
                     i, o, a, b, c, out_valid, sum, cout, exp_sum, exp_cout);
         end
`ifdef ADD_NEGATE_OVF_EN
         checks++;
         if (ovf !== exp_ovf) begin
            failures++;
            $display("FAIL b2b_ovf[%0d]: got %b need %b", i, ovf, exp_ovf);
         end
`endif
      end
      // Gap: no new operation, outputs hold the last result.
      in_valid = 1'b0;
      op       = 2'd3;
      Ra       = ~Ra;
      step();
      checks++;
      if (out_valid !== 1'b0 || sum !== exp_sum || cout !== exp_cout) begin
         failures++;
         $display("FAIL gap_hold: got vld=%b sum=%h cout=%b, need vld=0 sum=%h cout=%b",
                  out_valid, sum, cout, exp_sum, exp_cout);
      end
   endtask

   task automatic test_random_valid();
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic        v;
      logic [31:0] ns;
      logic        nc;
      logic        nv;
      for (int i = 0; i < 300; i++) begin
         o = 2'($urandom_range(0, 3));
         a = rand_operand();
         b = rand_operand();
         c = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 3) != 0);
         drive(o, a, b, c);
         in_valid = v;
         if (v) begin
            model(o, a, b, c, ns, nc, nv);
            exp_sum  = ns;
            exp_cout = nc;
            exp_ovf  = nv;
         end
         step();
         checks++;
         if (out_valid !== v || sum !== exp_sum || cout !== exp_cout) begin
            failures++;
            $display("FAIL rand[%0d] op=%0d a=%h b=%h cin=%b v=%b: got vld=%b sum=%h cout=%b, need vld=%b sum=%h cout=%b",
                     i, o, a, b, c, v, out_valid, sum, cout, v, exp_sum, exp_cout);
         end
`ifdef ADD_NEGATE_OVF_EN
         checks++;
         if (ovf !== exp_ovf) begin
            failures++;
            $display("FAIL rand_ovf[%0d]: got %b need %b", i, ovf, exp_ovf);
         end
`endif
      end
   endtask

   task automatic test_reset_midstream();
      drive(2'd0, 32'd40, 32'd2, 1'b0);
      step();
      clr = 1'b1;
      drive(2'd0, 32'd9, 32'd9, 1'b1);
      step();
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got vld=%b sum=%h cout=%b, need vld=0 sum=0 cout=0",
                  out_valid, sum, cout);
      end
      clr      = 1'b0;
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_after: got vld=%b sum=%h, need vld=0 sum=0",
                  out_valid, sum);
      end
   endtask

`ifdef ADD_NEGATE_OVF_EN
   task automatic test_ovf();
      logic [1:0]  o[3] = '{2'd0, 2'd1, 2'd0};
      logic [31:0] a[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
      logic [31:0] b[3] = '{32'd1, 32'd1, 32'd3};
      logic        ov[3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(o[i], a[i], b[i], 1'b0);
         step();
         checks++;
         if (ovf !== ov[i]) begin
            failures++;
            $display("FAIL ovf[%0d]: got %b need %b", i, ovf, ov[i]);
         end
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      exp_sum  = 32'd0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      clr      = 1'b1;
      in_valid = 1'b0;
      op       = 2'd0;
      Ra       = 32'd0;
      Rb       = 32'd0;
      cin      = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_neg();
      test_back_to_back();
      test_random_valid();
      test_reset_midstream();
`ifdef ADD_NEGATE_OVF_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
